// File: rtl/div_arb_pkg.sv
// div_arb_pkg
// Shared types and constants for the divider arbiter.
//   state_t        : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   DIV0_QUOTIENT  : all-ones pattern returned as the quotient on divide-by-zero,
//                    sliced down to the operand width by the user (widths up to 64)
//   wd_width()     : bit width needed to count a watchdog up to TIMEOUT
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned MAX_WIDTH_LIMIT = 64;
    localparam logic [MAX_WIDTH_LIMIT-1:0] DIV0_QUOTIENT = '1;

    function automatic int unsigned wd_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin grant. The search starts at the requester just
// after i_ptr and wraps, so the last winner has the lowest priority.
// Ports:
//   i_req   : request vector
//   i_ptr   : index of the previous winner
//   o_grant : one-hot grant (all zero when nothing requests)
//   o_idx   : index of the granted requester (0 when nothing requests)
//   o_any   : at least one request is present
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_best_i;
    int w_best_d;
    int w_dist;

    // Pick the requester with the smallest rotated distance from i_ptr+1.
    always_comb begin
        w_best_i = 0;
        w_best_d = int'(N);
        w_dist   = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (i_req[i]) begin
                w_dist = (i + 2 * int'(N) - int'(i_ptr) - 1) % int'(N);
                if (w_dist < w_best_d) begin
                    w_best_d = w_dist;
                    w_best_i = i;
                end
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < int'(N); i++) begin
            o_grant[i] = o_any && (i == w_best_i);
        end
    end

    assign o_any = |i_req;
    assign o_idx = IDX_W'(w_best_i);

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
// Shares one external long divider among NUM_REQ requesters. A request is
// accepted in IDLE, started on the divider with a one-cycle pulse, and the
// result is held on the shared response bus until the owner consumes it.
// Divide-by-zero is answered without touching the divider; a watchdog turns a
// hung divider into an error response.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid / req_ready        : per-requester request handshake (ready one-hot)
//   req_dividend / req_divisor   : packed operands, requester i at slice i
//   rsp_valid / rsp_ready        : per-requester response handshake (valid one-hot)
//   rsp_quotient / rsp_remainder : shared result bus
//   rsp_err                      : divide-by-zero or timeout
//   div_start_op                 : one-cycle start pulse to the divider
//   div_dividend / div_divisor   : operands to the divider, stable through WAIT
//   div_quotient / div_remainder : divider result
//   div_done                     : divider result valid (only looked at in WAIT)
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*MAX_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*MAX_WIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [MAX_WIDTH-1:0]           rsp_quotient,
    output logic [MAX_WIDTH-1:0]           rsp_remainder,
    output logic                           rsp_err,
    output logic                           div_start_op,
    output logic [MAX_WIDTH-1:0]           div_dividend,
    output logic [MAX_WIDTH-1:0]           div_divisor,
    input  logic [MAX_WIDTH-1:0]           div_quotient,
    input  logic [MAX_WIDTH-1:0]           div_remainder,
    input  logic                           div_done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = wd_width(TIMEOUT);
    // The watchdog is compared before it increments, so the exit value is
    // TIMEOUT-2; that makes the error response appear TIMEOUT cycles after ISSUE.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [MAX_WIDTH-1:0] r_dvd;
    logic [MAX_WIDTH-1:0] r_dvs;
    logic [MAX_WIDTH-1:0] r_quot;
    logic [MAX_WIDTH-1:0] r_rem;
    logic                 r_err;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_start;
    logic [WD_W-1:0]      r_wd;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_accept;
    logic [MAX_WIDTH-1:0] w_sel_dvd;
    logic [MAX_WIDTH-1:0] w_sel_dvs;
    logic [NUM_REQ-1:0]   w_owner_1h;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_dvd = '0;
        w_sel_dvs = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) begin
                w_sel_dvd = req_dividend[i*MAX_WIDTH +: MAX_WIDTH];
                w_sel_dvs = req_divisor[i*MAX_WIDTH +: MAX_WIDTH];
            end
        end
    end

    // Gated by rst so nothing appears accepted while reset is held.
    assign w_accept   = (r_state == IDLE) && w_any && !rst;
    assign req_ready  = w_accept ? w_grant : '0;
    assign w_owner_1h = NUM_REQ'(1) << r_owner;

    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_quot;
    assign rsp_remainder = r_rem;
    assign rsp_err       = r_err;
    assign div_start_op  = r_start;
    assign div_dividend  = r_dvd;
    assign div_divisor   = r_dvs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
            r_start     <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr   <= w_idx;
                        r_owner <= w_idx;
                        r_dvd   <= w_sel_dvd;
                        r_dvs   <= w_sel_dvs;
                        if (w_sel_dvs == '0) begin
                            r_quot      <= DIV0_QUOTIENT[MAX_WIDTH-1:0];
                            r_rem       <= w_sel_dvd;
                            r_err       <= 1'b1;
                            r_rsp_valid <= w_grant;
                            r_state     <= RESP;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // done has priority over a coincident timeout
                    if (div_done) begin
                        r_quot      <= div_quotient;
                        r_rem       <= div_remainder;
                        r_err       <= 1'b0;
                        r_rsp_valid <= w_owner_1h;
                        r_state     <= RESP;
                    end else if (r_wd == WD_LAST) begin
                        r_quot      <= '0;
                        r_rem       <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= w_owner_1h;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int NR      = 4;
    localparam int MW      = 16;
    localparam int TO      = 64;
    localparam int DIV_LAT = 18;

    typedef struct packed {
        logic [NR-1:0] vld;
        logic [MW-1:0] q;
        logic [MW-1:0] r;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*MW-1:0]  req_dividend = '0;
    logic [NR*MW-1:0]  req_divisor = '0;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready = '0;
    logic [MW-1:0]     rsp_quotient;
    logic [MW-1:0]     rsp_remainder;
    logic              rsp_err;
    logic              div_start_op;
    logic [MW-1:0]     div_dividend;
    logic [MW-1:0]     div_divisor;
    logic [MW-1:0]     div_quotient;
    logic [MW-1:0]     div_remainder;
    logic              div_done;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    div_arbiter #(
        .NUM_REQ   (NR),
        .MAX_WIDTH (MW),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .div_start_op  (div_start_op),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done)
    );

    always #5 clk = ~clk;

    // Behavioural divider: fixed latency, optional hang, optional stray done.
    logic [MW-1:0] m_q, m_r;
    logic          m_done;
    int            m_cnt;
    logic          hang = 1'b0;
    logic          stray = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (div_start_op) begin
                m_cnt <= DIV_LAT;
                if (div_divisor != '0) begin
                    m_q <= div_dividend / div_divisor;
                    m_r <= div_dividend % div_divisor;
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !hang) m_done <= 1'b1;
            end
        end
    end

    assign div_done      = m_done | stray;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    int cyc = 0;
    int start_cyc = 0;
    int n_starts = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start_op) begin
            n_starts  <= n_starts + 1;
            start_cyc <= cyc;
        end
    end

    // Drive a request until granted; push the expected response on accept.
    task automatic send(input int idx, input logic [MW-1:0] dvd, input logic [MW-1:0] dvs,
                        input bit tmo);
        exp_t e;
        bit   got = 1'b0;
        req_dividend[idx*MW +: MW] = dvd;
        req_divisor[idx*MW +: MW]  = dvs;
        req_valid[idx]             = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (req_ready[idx]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_wait: req_ready[%0d] never seen, required 1", idx);
            req_valid[idx] = 1'b0;
            return;
        end
        e.vld = NR'(1) << idx;
        if (tmo) begin
            e.q = '0; e.r = '0; e.err = 1'b1;
        end else if (dvs == '0) begin
            e.q = '1; e.r = dvd; e.err = 1'b1;
        end else begin
            e.q = dvd / dvs; e.r = dvd % dvs; e.err = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rsp_valid != '0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_wait: rsp_valid=%b after 200 cycles, required nonzero", rsp_valid);
    endtask

    task automatic ack(input int idx);
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start_op,
             div_dividend, div_divisor} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b q=%h r=%h e=%b st=%b dd=%h ds=%h, required 0",
                     rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start_op,
                     div_dividend, div_divisor);
        end
        req_valid = '1;
        #1;
        n_cmp++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b during reset, required 0000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fairness;
        logic [MW-1:0] fd[NR];
        logic [MW-1:0] fs[NR];
        exp_t e;
        bit   got, ok;
        int   gi;
        for (int i = 0; i < NR; i++) begin
            fd[i] = MW'(1000 + 257 * i);
            fs[i] = MW'(3 + 2 * i);
            req_dividend[i*MW +: MW] = fd[i];
            req_divisor[i*MW +: MW]  = fs[i];
        end
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                #1;
                if (req_ready != '0) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL fair_wait: no grant for round %0d", g);
                break;
            end
            n_cmp++;
            if (req_ready !== (NR'(1) << (g % NR))) begin
                n_fail++;
                $display("FAIL fair_grant: round %0d req_ready=%b, required %b",
                         g, req_ready, NR'(1) << (g % NR));
            end
            gi = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
            e.vld = NR'(1) << gi;
            e.q   = fd[gi] / fs[gi];
            e.r   = fd[gi] % fs[gi];
            e.err = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            #1;
            wait_rsp(ok);
            if (ok) begin
                e = sb.pop_front();
                n_cmp++;
                if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                    n_fail++;
                    $display("FAIL fair_rsp: round %0d got %b/%h/%h/%b, required %b/%h/%h/%b", g,
                             rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                             e.vld, e.q, e.r, e.err);
                end
            end
            if (g == 4) req_valid = '0;
            ack(gi);
        end
        req_valid = '0;
    endtask

    task automatic test_single;
        exp_t e;
        bit   ok;
        int   s0 = n_starts;
        send(0, 16'd100, 16'd7, 1'b0);
        wait_rsp(ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {4'b0001, 16'd14, 16'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL single_rsp: got %b/%0d/%0d/%b, required 0001/14/2/0",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
            end
        end
        n_cmp++;
        if (n_starts - s0 !== 1) begin
            n_fail++;
            $display("FAIL single_start: %0d start cycles, required 1", n_starts - s0);
        end
        ack(0);
    endtask

    task automatic test_div0;
        exp_t e;
        int   s0 = n_starts;
        send(2, 16'h1234, 16'h0000, 1'b0);
        // one cycle after accept the response must already be there
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                n_fail++;
                $display("FAIL div0_rsp: got %b/%h/%h/%b, required %b/%h/%h/%b",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                         e.vld, e.q, e.r, e.err);
            end
        end
        n_cmp++;
        if (n_starts != s0) begin
            n_fail++;
            $display("FAIL div0_start: %0d start cycles, required 0", n_starts - s0);
        end
        ack(2);
    endtask

    task automatic test_backpressure;
        exp_t e;
        bit   ok;
        logic [3*MW:0] snap;
        send(1, 16'd5000, 16'd13, 1'b0);
        wait_rsp(ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                n_fail++;
                $display("FAIL bp_rsp: got %b/%h/%h/%b, required %b/%h/%h/%b",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                         e.vld, e.q, e.r, e.err);
            end
            snap = {rsp_valid, rsp_quotient, rsp_remainder, rsp_err};
            // a competing request and non-owner ready must not disturb RESP
            req_dividend[0*MW +: MW] = 16'd777;
            req_divisor[0*MW +: MW]  = 16'd5;
            req_valid[0]             = 1'b1;
            rsp_ready                = 4'b0101;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                #1;
                n_cmp++;
                if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== snap || req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL bp_hold: cycle %0d rsp=%h ready=%b, required %h 0000",
                             c, {rsp_valid, rsp_quotient, rsp_remainder, rsp_err}, req_ready, snap);
                end
            end
            rsp_ready = '0;
            ack(1);
            send(0, 16'd777, 16'd5, 1'b0);
            wait_rsp(ok);
            if (ok) begin
                e = sb.pop_front();
                n_cmp++;
                if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                    n_fail++;
                    $display("FAIL bp_next: got %b/%h/%h/%b, required %b/%h/%h/%b",
                             rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                             e.vld, e.q, e.r, e.err);
                end
            end
            ack(0);
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_timeout;
        exp_t e;
        bit   ok;
        int   sc;
        hang = 1'b1;
        send(3, 16'd500, 16'd3, 1'b1);
        wait_rsp(ok);
        if (ok) begin
            sc = start_cyc;
            n_cmp++;
            if (cyc - sc !== TO) begin
                n_fail++;
                $display("FAIL tmo_latency: response %0d cycles after ISSUE, required %0d",
                         cyc - sc, TO);
            end
            e = sb.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                n_fail++;
                $display("FAIL tmo_rsp: got %b/%h/%h/%b, required %b/%h/%h/%b",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                         e.vld, e.q, e.r, e.err);
            end
            ack(3);
        end
        hang  = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== '0 || div_start_op !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_done: rsp_valid=%b start=%b, required 0000 0",
                     rsp_valid, div_start_op);
        end
        send(3, 16'd1000, 16'd9, 1'b0);
        wait_rsp(ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                n_fail++;
                $display("FAIL tmo_next: got %b/%h/%h/%b, required %b/%h/%h/%b",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                         e.vld, e.q, e.r, e.err);
            end
            ack(3);
        end
    endtask

    task automatic test_reset_in_wait;
        exp_t e;
        bit   got, ok;
        send(2, 16'd999, 16'd3, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (div_dividend !== 16'd999 || div_divisor !== 16'd3) begin
            n_fail++;
            $display("FAIL wait_operands: got %0d/%0d, required 999/3", div_dividend, div_divisor);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start_op,
             div_dividend, div_divisor} !== '0) begin
            n_fail++;
            $display("FAIL rst_wait_outputs: rv=%b q=%h r=%h e=%b st=%b dd=%h ds=%h, required 0",
                     rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start_op,
                     div_dividend, div_divisor);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_dividend[i*MW +: MW] = MW'(60 + i);
            req_divisor[i*MW +: MW]  = MW'(7);
        end
        req_valid = '1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (req_ready != '0) got = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_first_grant: req_ready=%b, required 0001", req_ready);
        end
        e.vld = 4'b0001; e.q = 16'd8; e.r = 16'd4; e.err = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_rsp(ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== e) begin
                n_fail++;
                $display("FAIL rst_next_rsp: got %b/%h/%h/%b, required %b/%h/%h/%b",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                         e.vld, e.q, e.r, e.err);
            end
            ack(0);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_div0();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Round-robin arbiter and sequencer that shares one LongDivisor instance among NUM_REQ requesters.
- Accepts divide requests per requester over a valid/ready handshake.
- Issues each accepted request to the divider as a one-cycle start pulse, waits for done, and returns quotient/remainder to the owning requester over a valid/ready response handshake.
- Short-circuits divide-by-zero and guards against a hung divider with a watchdog.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_WIDTH, 16, operand/result width; must equal the divider's MAX_WIDTH
TIMEOUT, 64, cycles allowed in WAIT before an error response (must exceed MAX_WIDTH+4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot; accept strobe for the granted requester
req_dividend  in  NUM_REQ*MAX_WIDTH  packed dividends; requester i at slice i
req_divisor  in  NUM_REQ*MAX_WIDTH  packed divisors
rsp_valid  out  NUM_REQ  one-hot; response pending for that requester
rsp_ready  in  NUM_REQ  response consumed
rsp_quotient  out  MAX_WIDTH  result quotient, shared bus
rsp_remainder  out  MAX_WIDTH  result remainder, shared bus
rsp_err  out  1  1 = divide-by-zero or timeout
div_start_op  out  1  one-cycle start pulse to the divider
div_dividend  out  MAX_WIDTH  operand to the divider
div_divisor  out  MAX_WIDTH  operand to the divider
div_quotient  in  MAX_WIDTH  divider result
div_remainder  in  MAX_WIDTH  divider result
div_done  in  1  divider result valid (qualified only in WAIT)

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = NUM_REQ-1 (requester 0 wins first), watchdog 0. Reset mid-operation aborts everything with no response. The divider shares rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid set:
  - grant g = first set bit searching from pointer+1, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally this cycle only; operands latched; owner:=g; pointer:=g.
  - divisor==0 → RESP with quotient={MAX_WIDTH{1}}, remainder=dividend, rsp_err=1; divider not started.
  - otherwise → ISSUE.
- IDLE, no req_valid: stay; req_ready=0.
- ISSUE: div_start_op=1 for exactly one cycle; div_dividend/div_divisor driven from the latched operands and held stable through WAIT; → WAIT, watchdog cleared.
- WAIT: watchdog increments each cycle.
  - div_done=1 → capture div_quotient/div_remainder, rsp_err=0, → RESP.
  - watchdog reaches TIMEOUT-1 without done → rsp_err=1, quotient=remainder=0, → RESP.
  - done in the same cycle as the timeout: done wins.
- RESP: rsp_valid[owner]=1; result buses held stable until rsp_ready[owner]=1, then → IDLE with rsp_valid cleared next cycle.
  - rsp_ready of non-owners is ignored.
  - req_ready stays 0 in ISSUE, WAIT and RESP.
- Latency: zero-divisor request to response = 1 cycle. Normal request: accept, +1 ISSUE, +divider latency WAIT, +1 RESP. Back-to-back requests need at least one IDLE cycle between them.
- div_done seen outside WAIT (late done after timeout) is ignored.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Quotient/remainder are unsigned, MAX_WIDTH bits; no width conversion.

Decomposition:
- Package div_arb_pkg: state enum typedef (IDLE, ISSUE, WAIT, RESP), the all-ones quotient constant for divide-by-zero, and the watchdog width function $clog2(TIMEOUT+1).
- One natural sub-module, rr_arbiter: combinational round-robin grant with pointer input, one-hot grant plus index output. It is reusable elsewhere.
- The divider itself stays external; the bench and top connect the LongDivisor instance to the div_* ports.

Test Plan:
- Single request: req 0 dividend=100, divisor=7 → one div_start_op pulse; rsp_valid=0001, quotient=14, remainder=2, rsp_err=0.
- Divide-by-zero: req 2 dividend=0x1234, divisor=0 → no div_start_op; next cycle rsp_valid=0100, quotient=0xFFFF, remainder=0x1234, rsp_err=1.
- Fairness: all 4 req_valid held high with distinct operands → grant order 0,1,2,3,0. Each response matches dividend/divisor and dividend%divisor, checked against a reference model.
- Response backpressure: req 1 result with rsp_ready held low 10 cycles → rsp_valid and buses stable; no new req_ready until rsp_ready[1]=1.
- Timeout: divider model never asserts done, TIMEOUT=64 → rsp_err=1 exactly 64 cycles after ISSUE. A later stray div_done is ignored, and the next request completes correctly.
- Reset in WAIT: rst asserted mid-division → all outputs 0 immediately; after release, requester 0 is granted first.
